// File: rtl/input_route_ctrl.sv
// Head-of-line route controller: XY-routes each head flit from the input FIFO and locks the
// chosen output port for the rest of the packet. Data passes through combinationally.
module input_route_ctrl #(
  parameter int unsigned WIDTH    = 34,
  parameter int unsigned X_W      = 2,
  parameter int unsigned Y_W      = 2,
  parameter int unsigned SZ_W     = 8,
  parameter int unsigned ROUTER_X = 0,
  parameter int unsigned ROUTER_Y = 0
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             fifo_empty_i,
  input  logic [WIDTH-1:0] fifo_data_i,
  output logic             fifo_read_o,
  output logic [4:0]       out_valid_o,
  input  logic [4:0]       out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic             busy_o,
  output logic [2:0]       lock_dir_o
);

  localparam logic [2:0] DirN = 3'd0;
  localparam logic [2:0] DirS = 3'd1;
  localparam logic [2:0] DirE = 3'd2;
  localparam logic [2:0] DirW = 3'd3;
  localparam logic [2:0] DirL = 3'd4;

  localparam logic [X_W-1:0] RouterX = X_W'(ROUTER_X);
  localparam logic [Y_W-1:0] RouterY = Y_W'(ROUTER_Y);

  localparam int unsigned YMsb  = WIDTH - 1 - X_W;
  localparam int unsigned SzMsb = WIDTH - 1 - X_W - Y_W;

  typedef enum logic [0:0] {StIdle, StBody} state_e;

  state_e            state_q, state_d;
  logic [SZ_W-1:0]   remaining_q, remaining_d;
  logic [2:0]        lock_dir_q, lock_dir_d;

  logic [X_W-1:0]    x_dst;
  logic [Y_W-1:0]    y_dst;
  logic [SZ_W-1:0]   pkt_size;
  logic [2:0]        route_dir;
  logic [2:0]        cur_dir;
  logic [4:0]        valid;
  logic              xfer;

  assign x_dst    = fifo_data_i[WIDTH-1 -: X_W];
  assign y_dst    = fifo_data_i[YMsb -: Y_W];
  assign pkt_size = fifo_data_i[SzMsb -: SZ_W];

  always_comb begin
    if (x_dst > RouterX) begin
      route_dir = DirE;
    end else if (x_dst < RouterX) begin
      route_dir = DirW;
    end else if (y_dst > RouterY) begin
      route_dir = DirN;
    end else if (y_dst < RouterY) begin
      route_dir = DirS;
    end else begin
      route_dir = DirL;
    end
  end

  // Body flits follow the latched port; their routing fields are payload.
  always_comb begin
    cur_dir = (state_q == StBody) ? lock_dir_q : route_dir;
    valid   = '0;
    if (arst_n && !fifo_empty_i) begin
      valid = 5'(1) << cur_dir;
    end
  end

  assign xfer = |(valid & out_ready_i);

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    lock_dir_d  = lock_dir_q;
    unique case (state_q)
      StIdle: begin
        if (xfer && (pkt_size != '0)) begin
          remaining_d = pkt_size;
          lock_dir_d  = route_dir;
          state_d     = StBody;
        end
      end
      StBody: begin
        if (xfer) begin
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == SZ_W'(1)) begin
            lock_dir_d = '0;
            state_d    = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      lock_dir_q  <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      lock_dir_q  <= lock_dir_d;
    end
  end

  assign out_valid_o = valid;
  assign fifo_read_o = xfer;
  assign out_data_o  = fifo_data_i;
  assign busy_o      = arst_n && (state_q == StBody);
  assign lock_dir_o  = arst_n ? lock_dir_q : 3'd0;

  assert property (@(posedge clk) !(fifo_read_o && fifo_empty_i));
  assert property (@(posedge clk) $onehot0(out_valid_o));

endmodule

// File: tb/tb_input_route_ctrl.sv
// Bench for input_route_ctrl at router (1,1): a raw flit stream is parsed into packets by the
// model, which gives each flit its expected output port; DUT outputs are checked every cycle.
module tb_input_route_ctrl;

  localparam int WIDTH = 34;

  logic             clk;
  logic             arst_n;
  logic             fifo_empty_i;
  logic [WIDTH-1:0] fifo_data_i;
  logic             fifo_read_o;
  logic [4:0]       out_valid_o;
  logic [4:0]       out_ready_i;
  logic [WIDTH-1:0] out_data_o;
  logic             busy_o;
  logic [2:0]       lock_dir_o;

  input_route_ctrl #(
    .WIDTH(34), .X_W(2), .Y_W(2), .SZ_W(8), .ROUTER_X(1), .ROUTER_Y(1)
  ) dut (
    .clk         (clk),
    .arst_n      (arst_n),
    .fifo_empty_i(fifo_empty_i),
    .fifo_data_i (fifo_data_i),
    .fifo_read_o (fifo_read_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .busy_o      (busy_o),
    .lock_dir_o  (lock_dir_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Stream model: raw flits, plus per-flit expected port and body flag derived by parsing.
  logic [WIDTH-1:0] sd[$];
  int               sp[$];
  bit               sb[$];
  int               pos = 0;

  function automatic int route(int x, int y);
    if (x > 1) return 2;
    if (x < 1) return 3;
    if (y > 1) return 0;
    if (y < 1) return 1;
    return 4;
  endfunction

  function automatic logic [WIDTH-1:0] make_flit(int x, int y, int sz);
    logic [1:0] xx = 2'(x);
    logic [1:0] yy = 2'(y);
    logic [7:0] ss = 8'(sz);
    logic [21:0] pl = 22'($urandom);
    return {xx, yy, ss, pl};
  endfunction

  task automatic annotate();
    int left = 0;
    int port = 0;
    sp.delete();
    sb.delete();
    for (int i = 0; i < sd.size(); i++) begin
      if (left == 0) begin
        port = route(int'(sd[i][33:32]), int'(sd[i][31:30]));
        left = int'(sd[i][29:22]);
        sp.push_back(port);
        sb.push_back(1'b0);
      end else begin
        left--;
        sp.push_back(port);
        sb.push_back(1'b1);
      end
    end
  endtask

  // Body flits carry the given fields (negative bx means random bits).
  task automatic add_packet(int x, int y, int sz, int bx, int by);
    logic [63:0] r;
    sd.push_back(make_flit(x, y, sz));
    for (int i = 0; i < sz; i++) begin
      if (bx < 0) begin
        r = {$urandom, $urandom};
        sd.push_back(r[WIDTH-1:0]);
      end else begin
        sd.push_back(make_flit(bx, by, $urandom_range(0, 255)));
      end
    end
    annotate();
  endtask

  task automatic step(string tag, bit present, logic [4:0] ready);
    bit          have;
    logic [4:0]  exp_valid;
    logic        exp_read;
    logic        exp_busy;
    logic [2:0]  exp_lock;
    logic [63:0] r;
    have = present && (pos < sd.size());
    r = {$urandom, $urandom};
    fifo_empty_i = !have;
    fifo_data_i  = have ? sd[pos] : r[WIDTH-1:0];
    out_ready_i  = ready;
    exp_valid = have ? (5'(1) << sp[pos]) : 5'd0;
    exp_read  = |(exp_valid & ready);
    exp_busy  = (pos < sd.size()) ? sb[pos] : 1'b0;
    exp_lock  = exp_busy ? 3'(sp[pos]) : 3'd0;
    @(negedge clk);
    checks++;
    if (out_valid_o !== exp_valid) begin
      errors++;
      $display("FAIL %s valid pos=%0d got %b want %b", tag, pos, out_valid_o, exp_valid);
    end
    checks++;
    if (fifo_read_o !== exp_read) begin
      errors++;
      $display("FAIL %s read pos=%0d got %b want %b", tag, pos, fifo_read_o, exp_read);
    end
    checks++;
    if (out_data_o !== fifo_data_i) begin
      errors++;
      $display("FAIL %s data got %h want %h", tag, out_data_o, fifo_data_i);
    end
    checks++;
    if (busy_o !== exp_busy) begin
      errors++;
      $display("FAIL %s busy pos=%0d got %b want %b", tag, pos, busy_o, exp_busy);
    end
    checks++;
    if (lock_dir_o !== exp_lock) begin
      errors++;
      $display("FAIL %s lock_dir pos=%0d got %0d want %0d", tag, pos, lock_dir_o, exp_lock);
    end
    @(posedge clk);
    if (exp_read) pos++;
    #1;
  endtask

  task automatic run_stream(string tag, int bound, bit randomize);
    int n = 0;
    bit present;
    logic [4:0] ready;
    while (pos < sd.size() && n < bound) begin
      present = randomize ? ($urandom_range(0, 9) != 0) : 1'b1;
      ready   = (randomize && $urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 31)) : 5'h1f;
      step(tag, present, ready);
      n++;
    end
    checks++;
    if (pos < sd.size()) begin
      errors++;
      $display("FAIL %s timeout consumed %0d want %0d", tag, pos, sd.size());
    end
  endtask

  task automatic do_reset();
    arst_n = 1'b0;
    fifo_empty_i = 1'b1;
    @(posedge clk);
    #1;
    arst_n = 1'b1;
    sd.delete();
    sp.delete();
    sb.delete();
    pos = 0;
  endtask

  task automatic check_reset_outputs(string tag);
    @(negedge clk);
    checks++;
    if ({out_valid_o, fifo_read_o, busy_o, lock_dir_o} !== 10'd0) begin
      errors++;
      $display("FAIL %s outputs got valid=%b read=%b busy=%b lock=%0d want all 0",
               tag, out_valid_o, fifo_read_o, busy_o, lock_dir_o);
    end
    checks++;
    if (out_data_o !== fifo_data_i) begin
      errors++;
      $display("FAIL %s data got %h want %h", tag, out_data_o, fifo_data_i);
    end
  endtask

  task automatic test_reset();
    arst_n       = 1'b0;
    fifo_empty_i = 1'b0;
    fifo_data_i  = make_flit(3, 0, 2);
    out_ready_i  = 5'h1f;
    repeat (2) begin
      @(posedge clk);
      #1;
      check_reset_outputs("reset");
    end
    do_reset();
    step("reset_idle", 1'b0, 5'h1f);
  endtask

  task automatic test_single_flit();
    do_reset();
    add_packet(1, 1, 0, -1, 0);
    step("single_stall", 1'b1, 5'b01111);
    step("single", 1'b1, 5'b10000);
    step("single_after", 1'b0, 5'h1f);
  endtask

  task automatic test_route_sweep();
    do_reset();
    add_packet(2, 1, 0, -1, 0);
    add_packet(0, 1, 0, -1, 0);
    add_packet(1, 2, 0, -1, 0);
    add_packet(1, 0, 0, -1, 0);
    add_packet(3, 3, 0, -1, 0);
    add_packet(0, 3, 0, -1, 0);
    run_stream("sweep", 20, 1'b0);
  endtask

  task automatic test_locked_packet();
    do_reset();
    add_packet(3, 1, 3, 0, 0);
    run_stream("locked", 20, 1'b0);
    step("locked_after", 1'b0, 5'h1f);
  endtask

  task automatic test_backpressure();
    do_reset();
    add_packet(3, 1, 3, 0, 0);
    step("bp_head", 1'b1, 5'h1f);
    step("bp_body", 1'b1, 5'h1f);
    repeat (5) step("bp_stall", 1'b1, 5'b11011);
    run_stream("bp_resume", 20, 1'b0);
    step("bp_after", 1'b0, 5'h1f);
  endtask

  task automatic test_empty_mid_packet();
    do_reset();
    add_packet(0, 2, 3, 1, 1);
    step("empty_head", 1'b1, 5'h1f);
    step("empty_body", 1'b1, 5'h1f);
    repeat (3) step("empty_gap", 1'b0, 5'h1f);
    step("empty_b2", 1'b1, 5'h1f);
    step("empty_b3", 1'b1, 5'h1f);
    step("empty_after", 1'b0, 5'h1f);
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    add_packet(1, 2, 4, 2, 1);
    step("rst_head", 1'b1, 5'h1f);
    step("rst_body", 1'b1, 5'h1f);
    arst_n       = 1'b0;
    fifo_empty_i = 1'b0;
    fifo_data_i  = sd[pos];
    out_ready_i  = 5'h1f;
    check_reset_outputs("rst_low");
    @(posedge clk);
    #1;
    arst_n = 1'b1;
    // Abandoned packet: the remaining flits are now parsed afresh as heads.
    for (int k = 0; k < pos; k++) void'(sd.pop_front());
    pos = 0;
    annotate();
    run_stream("rst_after", 20, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_reset();
    add_packet(3, 1, 2, -1, 0);
    add_packet(0, 1, 0, -1, 0);
    add_packet(1, 1, 255, -1, 0);
    add_packet(1, 0, 1, -1, 0);
    add_packet(2, 2, 0, -1, 0);
    run_stream("b2b", 400, 1'b0);
  endtask

  task automatic test_random();
    do_reset();
    for (int p = 0; p < 60; p++) begin
      add_packet($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 5), -1, 0);
    end
    run_stream("random", 5000, 1'b1);
    step("random_after", 1'b0, 5'h1f);
  endtask

  initial begin
    arst_n       = 1'b0;
    fifo_empty_i = 1'b1;
    fifo_data_i  = '0;
    out_ready_i  = '0;
    test_reset();
    test_single_flit();
    test_route_sweep();
    test_locked_packet();
    test_backpressure();
    test_empty_mid_packet();
    test_reset_mid_packet();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
